uart_receiver: RTL and testbench
================================

Name: uart_receiver

Overview:
UART serial receiver; the receive-side counterpart to the existing transmitter, and the DUT of the receive-path checks in the UART env.
- Samples asynchronous line rx at mid-bit using a clock-cycle bit counter.
- Deserialises LSB-first data and presents the word on dout with a one-cycle recv_ack strobe.
- Holds dout with a sticky valid flag until the consumer acknowledges with recv_req; reports frame, parity and overrun errors.

Parameters:
CLKS_PER_BIT, 16, clk cycles per UART bit; even, >= 4.
DATA_W, 8, data bits per frame (5..9).
PARITY_EN, 0, 1 = one even-parity bit after data; 0 = none.

Ports:
clk  in  1  system clock; all logic on rising edge.
rst_n  in  1  asynchronous active-low reset.
rx  in  1  serial line, idle high, asynchronous to clk.
recv_req  in  1  consumer read strobe; clears data_valid.
dout  out  DATA_W  last good received word; held until next good frame.
rx_sample  out  DATA_W  live deserialisation shift register.
recv_ack  out  1  one-cycle pulse: new word loaded into dout.
data_valid  out  1  sticky: dout unread.
frame_err  out  1  one-cycle pulse: stop bit sampled 0.
parity_err  out  1  one-cycle pulse: parity mismatch.
overrun  out  1  sticky: good frame completed while data_valid=1.
busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (async assert, sync release): state IDLE; counters 0; all outputs 0 except rx_s. Synchronizer flops reset to 1.
- rx passes a 2-flop synchronizer (rx_s); all decisions use rx_s only.
- Cycle counter cnt counts 0..CLKS_PER_BIT-1; bit index counts 0..DATA_W-1.
- States: IDLE, START, DATA, PARITY, STOP, BREAK.
- IDLE: rx_s==0 -> START, cnt<=0.
- START: at cnt==CLKS_PER_BIT/2-1 sample rx_s.
  - 0: go to DATA, cnt<=0.
  - 1: false start, return to IDLE; no flags raised.
- DATA: at cnt==CLKS_PER_BIT-1 shift rx_s into MSB of rx_sample (LSB-first); after DATA_W bits go to PARITY if PARITY_EN else STOP.
- PARITY: sample at cnt==CLKS_PER_BIT-1. Error if XOR(rx_sample, bit) != 0; latch flag internally, then go to STOP.
- STOP: sample at cnt==CLKS_PER_BIT-1.
  - rx_s==1, no parity error: next cycle recv_ack=1, dout<=rx_sample, data_valid<=1; overrun<=1 if data_valid was already 1. Go to IDLE.
  - rx_s==1, parity error: parity_err pulse; no recv_ack; dout unchanged; go to IDLE.
  - rx_s==0: frame_err pulse (also parity_err if flagged); no recv_ack; go to BREAK.
- BREAK: wait for rx_s==1, then IDLE. This prevents a held-low line from retriggering.
- Latency: let cycle 0 be the first cycle rx_s==0.
  - Stop sample at cycle CLKS_PER_BIT/2 + (DATA_W+PARITY_EN+1)*CLKS_PER_BIT.
  - recv_ack follows 1 cycle later; the raw-rx edge adds 2 synchronizer cycles.
  - Defaults: recv_ack 155 cycles after the raw rx falling edge.
- In the recv_ack cycle dout == rx_sample; this must hold for the env assertion.
- recv_req: clears data_valid next cycle and also clears overrun.
- Simultaneous recv_req and recv_ack: the new word wins; data_valid stays 1 and overrun is not set.
- Back-to-back frames: the STOP->IDLE return at mid stop bit leaves half a bit to detect the next start edge; no idle gap required.
- Reset mid-frame: immediately IDLE, outputs cleared, partial frame discarded.

Test Plan:
1. Defaults: send 0xA5, 8N1 -> recv_ack single pulse 155 cycles after rx edge; dout=0xA5=rx_sample; data_valid=1; no error flags.
2. 4-cycle low glitch on idle rx -> no recv_ack, no errors; busy pulses then returns to 0 by cycle 10.
3. Send 0x3C with stop bit 0 -> frame_err one pulse, no recv_ack, dout keeps prior 0xA5; state BREAK until rx high, then next 0x5A received correctly.
4. Back-to-back 0x00 then 0xFF with zero idle, no recv_req -> two recv_ack pulses 160 cycles apart; dout=0xFF; overrun=1; recv_req clears data_valid and overrun.
5. PARITY_EN=1: send 0x01 with parity bit 0 -> parity_err pulse, no recv_ack. Then 0x03 with parity 0 -> recv_ack, dout=0x03.
6. Assert rst_n low during DATA bit 4 of 0xFF -> all outputs 0 immediately. After release, a full 0x81 frame -> dout=0x81, no spurious ack from the aborted frame.

Source files
------------

// File: rtl/uart_receiver.sv
// UART receiver: samples rx at mid-bit, deserialises LSB-first words and reports frame/parity/overrun errors.
// Latency: recv_ack 2 sync cycles + CLKS_PER_BIT/2 + (DATA_W+PARITY_EN+1)*CLKS_PER_BIT + 1 cycles after the rx falling edge.
// Backpressure: none; dout is held with a sticky data_valid and an unread word is overwritten (flagged by overrun).
module uart_receiver #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_W       = 8,
    parameter int PARITY_EN    = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx,
    input  logic              recv_req,
    output logic [DATA_W-1:0] dout,
    output logic [DATA_W-1:0] rx_sample,
    output logic              recv_ack,
    output logic              data_valid,
    output logic              frame_err,
    output logic              parity_err,
    output logic              overrun,
    output logic              busy
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_W);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic [DATA_W-1:0]   dout_q, dout_d;
    logic                par_err_q, par_err_d;
    logic                ack_q, ack_d;
    logic                valid_q, valid_d;
    logic                ferr_q, ferr_d;
    logic                perr_q, perr_d;
    logic                ovr_q, ovr_d;
    logic                sync1_q, rx_s_q;
    logic                mid_tick, last_tick;

    assign mid_tick  = (cnt_q == CNT_W'(CLKS_PER_BIT/2 - 1));
    assign last_tick = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + CNT_W'(1);
        idx_d     = idx_q;
        shift_d   = shift_q;
        par_err_d = par_err_q;
        ack_d     = 1'b0;
        ferr_d    = 1'b0;
        perr_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d     = '0;
                par_err_d = 1'b0;
                if (!rx_s_q) state_d = S_START;
            end
            S_START: begin
                if (mid_tick) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = rx_s_q ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (last_tick) begin
                    cnt_d   = '0;
                    shift_d = {rx_s_q, shift_q[DATA_W-1:1]};
                    if (idx_q == IDX_W'(DATA_W - 1)) begin
                        state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            S_PARITY: begin
                if (last_tick) begin
                    cnt_d     = '0;
                    par_err_d = (^shift_q) ^ rx_s_q;
                    state_d   = S_STOP;
                end
            end
            S_STOP: begin
                if (last_tick) begin
                    cnt_d = '0;
                    if (rx_s_q) begin
                        perr_d  = par_err_q;
                        ack_d   = ~par_err_q;
                        state_d = S_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        perr_d  = par_err_q;
                        state_d = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                cnt_d = '0;
                if (rx_s_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // A new word landing together with a read keeps valid set and is not an overrun.
        dout_d  = ack_d ? shift_q : dout_q;
        valid_d = ack_d | (valid_q & ~recv_req);
        ovr_d   = recv_req ? 1'b0 : (ovr_q | (ack_d & valid_q));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= 1'b1;
            rx_s_q    <= 1'b1;
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            shift_q   <= '0;
            dout_q    <= '0;
            par_err_q <= 1'b0;
            ack_q     <= 1'b0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            perr_q    <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            sync1_q   <= rx;
            rx_s_q    <= sync1_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            shift_q   <= shift_d;
            dout_q    <= dout_d;
            par_err_q <= par_err_d;
            ack_q     <= ack_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
            perr_q    <= perr_d;
            ovr_q     <= ovr_d;
        end
    end

    assign dout       = dout_q;
    assign rx_sample  = shift_q;
    assign recv_ack   = ack_q;
    assign data_valid = valid_q;
    assign frame_err  = ferr_q;
    assign parity_err = perr_q;
    assign overrun    = ovr_q;
    assign busy       = (state_q != S_IDLE);
endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: default 8N1 instance plus an even-parity instance.
module tb_uart_receiver;
    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx, rx_p, recv_req;
    logic [7:0] dout, rx_sample, dout_p, rx_sample_p;
    logic       recv_ack, data_valid, frame_err, parity_err, overrun, busy;
    logic       recv_ack_p, data_valid_p, frame_err_p, parity_err_p, overrun_p, busy_p;

    uart_receiver #(.CLKS_PER_BIT(CPB), .DATA_W(8), .PARITY_EN(0)) u_dut (
        .clk(clk), .rst_n(rst_n), .rx(rx), .recv_req(recv_req),
        .dout(dout), .rx_sample(rx_sample), .recv_ack(recv_ack),
        .data_valid(data_valid), .frame_err(frame_err), .parity_err(parity_err),
        .overrun(overrun), .busy(busy)
    );

    uart_receiver #(.CLKS_PER_BIT(CPB), .DATA_W(8), .PARITY_EN(1)) u_dut_p (
        .clk(clk), .rst_n(rst_n), .rx(rx_p), .recv_req(1'b0),
        .dout(dout_p), .rx_sample(rx_sample_p), .recv_ack(recv_ack_p),
        .data_valid(data_valid_p), .frame_err(frame_err_p), .parity_err(parity_err_p),
        .overrun(overrun_p), .busy(busy_p)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_err = 0;

    int ack_cnt = 0, ack_cyc = 0, ack_mm = 0, ack_long = 0;
    int ferr_cnt = 0, ferr_long = 0, perr_cnt = 0, busy_cnt = 0;
    int ack_p_cnt = 0, ack_p_cyc = 0, perr_p_cnt = 0, ferr_p_cnt = 0;
    logic prev_ack = 1'b0, prev_ferr = 1'b0;

    always @(negedge clk) begin
        prev_ack  <= recv_ack;
        prev_ferr <= frame_err;
        if (recv_ack) begin
            ack_cnt <= ack_cnt + 1;
            ack_cyc <= cyc;
            if (dout !== rx_sample) ack_mm <= ack_mm + 1;
            if (prev_ack) ack_long <= ack_long + 1;
        end
        if (frame_err) begin
            ferr_cnt <= ferr_cnt + 1;
            if (prev_ferr) ferr_long <= ferr_long + 1;
        end
        if (parity_err) perr_cnt <= perr_cnt + 1;
        if (busy) busy_cnt <= busy_cnt + 1;
        if (recv_ack_p) begin
            ack_p_cnt <= ack_p_cnt + 1;
            ack_p_cyc <= cyc;
        end
        if (parity_err_p) perr_p_cnt <= perr_p_cnt + 1;
        if (frame_err_p) ferr_p_cnt <= ferr_p_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    int start_cyc = 0;

    task automatic drive(input bit which, input logic v);
        if (which) rx_p = v;
        else       rx   = v;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send(input bit which, input logic [7:0] data, input bit par_en,
                        input logic par, input logic stop);
        start_cyc = cyc;
        drive(which, 1'b0);
        for (int i = 0; i < 8; i++) drive(which, data[i]);
        if (par_en) drive(which, par);
        drive(which, stop);
    endtask

    task automatic read_word();
        recv_req = 1'b1;
        @(negedge clk);
        recv_req = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    int a0, b0, f0, p0, t0;

    initial begin
        rst_n = 1'b0; rx = 1'b1; rx_p = 1'b1; recv_req = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_dout", {24'd0, dout}, 32'h0);
        chk("rst_rx_sample", {24'd0, rx_sample}, 32'h0);
        chk("rst_flags", {26'd0, recv_ack, data_valid, frame_err, parity_err, overrun, busy}, 32'h0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // 1: 0xA5 8N1
        a0 = ack_cnt;
        send(1'b0, 8'hA5, 1'b0, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        chk("t1_ack_count", ack_cnt - a0, 1);
        chk("t1_latency", ack_cyc - start_cyc, 155);
        chk("t1_dout", {24'd0, dout}, 32'hA5);
        chk("t1_rx_sample", {24'd0, rx_sample}, 32'hA5);
        chk("t1_valid", {31'd0, data_valid}, 1);
        chk("t1_ferr", ferr_cnt, 0);
        chk("t1_overrun", {31'd0, overrun}, 0);
        chk("t1_busy", {31'd0, busy}, 0);

        // 2: 4-cycle glitch
        a0 = ack_cnt; b0 = busy_cnt;
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        repeat (8) @(negedge clk);
        chk("t2_busy_idle", {31'd0, busy}, 0);
        chk("t2_busy_cycles", busy_cnt - b0, 8);
        chk("t2_no_ack", ack_cnt - a0, 0);
        chk("t2_no_ferr", ferr_cnt, 0);

        // 3: bad stop bit, line held low, then recovery
        a0 = ack_cnt; f0 = ferr_cnt;
        send(1'b0, 8'h3C, 1'b0, 1'b0, 1'b0);
        repeat (40) @(negedge clk);
        chk("t3_break_busy", {31'd0, busy}, 1);
        chk("t3_ferr", ferr_cnt - f0, 1);
        chk("t3_no_ack", ack_cnt - a0, 0);
        chk("t3_dout_kept", {24'd0, dout}, 32'hA5);
        rx = 1'b1;
        repeat (4) @(negedge clk);
        chk("t3_idle", {31'd0, busy}, 0);
        send(1'b0, 8'h5A, 1'b0, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        chk("t3_ack", ack_cnt - a0, 1);
        chk("t3_dout", {24'd0, dout}, 32'h5A);
        chk("t3_overrun", {31'd0, overrun}, 1);
        read_word();
        chk("t3_read_valid", {31'd0, data_valid}, 0);
        chk("t3_read_ovr", {31'd0, overrun}, 0);

        // 4: back-to-back 0x00, 0xFF
        a0 = ack_cnt;
        send(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        t0 = ack_cyc;
        send(1'b0, 8'hFF, 1'b0, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        chk("t4_acks", ack_cnt - a0, 2);
        chk("t4_spacing", ack_cyc - t0, 160);
        chk("t4_dout", {24'd0, dout}, 32'hFF);
        chk("t4_overrun", {31'd0, overrun}, 1);
        chk("t4_valid", {31'd0, data_valid}, 1);
        read_word();
        chk("t4_read_valid", {31'd0, data_valid}, 0);
        chk("t4_read_ovr", {31'd0, overrun}, 0);

        // 5: even parity instance
        a0 = ack_p_cnt; p0 = perr_p_cnt;
        send(1'b1, 8'h01, 1'b1, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        chk("t5_perr", perr_p_cnt - p0, 1);
        chk("t5_no_ack", ack_p_cnt - a0, 0);
        send(1'b1, 8'h03, 1'b1, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        chk("t5_ack", ack_p_cnt - a0, 1);
        chk("t5_latency", ack_p_cyc - start_cyc, 171);
        chk("t5_dout", {24'd0, dout_p}, 32'h03);
        chk("t5_rx_sample", {24'd0, rx_sample_p}, 32'h03);
        chk("t5_perr_once", perr_p_cnt - p0, 1);
        chk("t5_state", {29'd0, data_valid_p, overrun_p, busy_p}, 32'h4);
        chk("t5_no_ferr", ferr_p_cnt, 0);

        // 6: reset during data bit 4 of 0xFF
        a0 = ack_cnt;
        drive(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b1);
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_dout", {24'd0, dout}, 32'h0);
        chk("t6_rst_rx_sample", {24'd0, rx_sample}, 32'h0);
        chk("t6_rst_flags", {26'd0, recv_ack, data_valid, frame_err, parity_err, overrun, busy}, 32'h0);
        @(negedge clk);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        send(1'b0, 8'h81, 1'b0, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        chk("t6_ack", ack_cnt - a0, 1);
        chk("t6_dout", {24'd0, dout}, 32'h81);
        chk("t6_valid", {31'd0, data_valid}, 1);

        chk("ack_eq_sample", ack_mm, 0);
        chk("ack_width", ack_long, 0);
        chk("ferr_width", ferr_long, 0);
        chk("no_perr_8n1", perr_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
